// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch stage.
//   - opcode constants used by the IMem predecode
//   - default bubble word, fetch state and next-PC action encodings
//   - 16->32 sign-extend helper for jump offsets
package cpu_pkg;

    localparam logic [5:0]  OP_J       = 6'b000001;
    localparam logic [5:0]  OP_BR_BASE = 6'b100000;  // branch family 1000xx
    localparam logic [31:0] NOP_WORD   = 32'd0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BUBBLE,
        ST_HALT
    } fetch_state_t;

    // What the fetch stage does this cycle, as decided by if_next_pc.
    typedef enum logic [2:0] {
        ACT_SEQ,       // latch Instruction, PC+1
        ACT_LAST,      // latch Instruction at PROG_END, PC holds, go HALT
        ACT_JUMP,      // local jump: flush IR, PC <= PC+1+offset
        ACT_REDIRECT,  // execute redirect: flush IR, PC <= target
        ACT_HOLD,      // stall: everything holds
        ACT_IDLE       // halted: PC frozen, IR is a bubble
    } fetch_act_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: combinational next-PC and action select for the fetch stage.
// Priority: redirect > halt > stall > jump > sequential (PROG_END -> hold).
// Ports:
//   pc_i              current fetch PC
//   halted_i          fetch state is HALT
//   redirect_valid_i  taken branch from execute
//   redirect_target_i branch target word address
//   stall_i           hazard stall
//   jump_i            jump predecode (already gated by the feature macro)
//   jump_off_i        Instruction[15:0], jump offset relative to PC+1
//   pc_d_o            next PC
//   act_o             action for the IF/ID register and state update
module if_next_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] PROG_END = 32'd31
) (
    input  logic [31:0] pc_i,
    input  logic        halted_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [15:0] jump_off_i,
    output logic [31:0] pc_d_o,
    output fetch_act_t  act_o
);

    always_comb begin
        act_o  = ACT_SEQ;
        pc_d_o = pc_i + 32'd1;
        if (redirect_valid_i) begin
            act_o  = ACT_REDIRECT;
            pc_d_o = redirect_target_i;
        end else if (halted_i) begin
            // HALT wins over stall so the IR stays a bubble while halted.
            act_o  = ACT_IDLE;
            pc_d_o = pc_i;
        end else if (stall_i) begin
            act_o  = ACT_HOLD;
            pc_d_o = pc_i;
        end else if (jump_i) begin
            act_o  = ACT_JUMP;
            pc_d_o = pc_i + 32'd1 + sext16(jump_off_i);
        end else if (pc_i == PROG_END) begin
            act_o  = ACT_LAST;
            pc_d_o = pc_i;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage in front of IMem.
// Owns the PC, the IF/ID register (IR, IR_PC, IR_Valid, IR_Branch) and the
// RUN/BUBBLE/HALT state. Next-PC selection lives in if_next_pc.
// Optional feature macro: JUMP_PREDECODE_EN
//   defined   - IMem jump predecode is resolved here with one bubble
//   undefined - jump is ignored; j flows to decode and execute redirects
// Ports:
//   clk, reset        clock, async active-high reset
//   Instruction       IMem word at PC
//   jump, branch      IMem predecode flags for Instruction
//   Stall             hold PC and IF/ID
//   RedirectValid/Target  taken branch from execute
//   PC                fetch address to IMem
//   IR, IR_PC, IR_Valid, IR_Branch  IF/ID register
//   Halted            fetch is in HALT
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PROG_END = 32'd31,
    parameter logic [31:0] NOP_WORD = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic        jump,
    input  logic        branch,
    input  logic        Stall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] PC,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic        IR_Valid,
    output logic        IR_Branch,
    output logic        Halted
);

    import cpu_pkg::*;

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_pc_q;
    logic         ir_valid_q, ir_branch_q, halted_q;
    fetch_state_t state_q, state_d;
    fetch_act_t   act;
    logic         jump_en;

`ifdef JUMP_PREDECODE_EN
    assign jump_en = jump;
`else
    logic unused_jump;
    assign jump_en     = 1'b0;
    assign unused_jump = jump;
`endif

    if_next_pc #(
        .PROG_END(PROG_END)
    ) u_next_pc (
        .pc_i              (pc_q),
        .halted_i          (state_q == ST_HALT),
        .redirect_valid_i  (RedirectValid),
        .redirect_target_i (RedirectTarget),
        .stall_i           (Stall),
        .jump_i            (jump_en),
        .jump_off_i        (Instruction[15:0]),
        .pc_d_o            (pc_d),
        .act_o             (act)
    );

    always_comb begin
        state_d = state_q;
        case (act)
            ACT_SEQ:                state_d = ST_RUN;
            ACT_LAST:               state_d = ST_HALT;
            ACT_JUMP, ACT_REDIRECT: state_d = ST_BUBBLE;
            default:                state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ir_q        <= NOP_WORD;
            ir_pc_q     <= 32'd0;
            ir_valid_q  <= 1'b0;
            ir_branch_q <= 1'b0;
            halted_q    <= 1'b0;
            state_q     <= ST_RUN;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
            case (act)
                ACT_SEQ, ACT_LAST: begin
                    ir_q        <= Instruction;
                    ir_pc_q     <= pc_q;
                    ir_valid_q  <= 1'b1;
                    ir_branch_q <= branch;
                end
                ACT_JUMP, ACT_REDIRECT, ACT_IDLE: begin
                    // Wrong-path / halted slot becomes a bubble.
                    ir_q        <= NOP_WORD;
                    ir_valid_q  <= 1'b0;
                    ir_branch_q <= 1'b0;
                end
                default: ;  // ACT_HOLD
            endcase
        end
    end

    assign PC        = pc_q;
    assign IR        = ir_q;
    assign IR_PC     = ir_pc_q;
    assign IR_Valid  = ir_valid_q;
    assign IR_Branch = ir_branch_q;
    assign Halted    = halted_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic        jump, branch;
    logic        Stall, RedirectValid;
    logic [31:0] RedirectTarget;
    logic [31:0] PC, IR, IR_PC;
    logic        IR_Valid, IR_Branch, Halted;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .jump(jump),
        .branch(branch), .Stall(Stall), .RedirectValid(RedirectValid),
        .RedirectTarget(RedirectTarget), .PC(PC), .IR(IR), .IR_PC(IR_PC),
        .IR_Valid(IR_Valid), .IR_Branch(IR_Branch), .Halted(Halted)
    );

    // Program image: words 0..31, NOP beyond PROG_END.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a > 32'd31)  return 32'd0;
        if (a == 32'd3)  return 32'h8000_0003;   // branch opcode 100000
        if (a == 32'd21) return 32'h0400_FFEA;   // j, offset -22
        return 32'hA000_0000 + a * 32'h0001_0101;
    endfunction

    function automatic logic is_j(input logic [31:0] w);
        return w[31:26] == 6'b000001;
    endfunction

    function automatic logic is_br(input logic [31:0] w);
        return w[31:28] == 4'b1000;
    endfunction

    // IMem with predecode
    assign Instruction = word(PC);
    assign jump        = is_j(Instruction);
    assign branch      = is_br(Instruction);

`ifdef JUMP_PREDECODE_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    // Reference model: fetches from its own PC using the program image.
    logic [31:0] m_pc, m_ir, m_irpc;
    logic        m_v, m_br, m_halt;

    always @(posedge clk or posedge reset) begin
        logic [31:0] w;
        if (reset) begin
            m_pc = 32'd0; m_ir = 32'd0; m_irpc = 32'd0;
            m_v = 1'b0; m_br = 1'b0; m_halt = 1'b0;
        end else begin
            w = word(m_pc);
            if (RedirectValid) begin
                m_pc = RedirectTarget; m_ir = 32'd0; m_v = 1'b0; m_halt = 1'b0;
            end else if (m_halt) begin
                m_ir = 32'd0; m_v = 1'b0;
            end else if (Stall) begin
                // hold
            end else if (JEN && is_j(w)) begin
                m_pc = m_pc + 32'd1 + {{16{w[15]}}, w[15:0]};
                m_ir = 32'd0; m_v = 1'b0;
            end else begin
                m_ir = w; m_irpc = m_pc; m_v = 1'b1; m_br = is_br(w);
                if (m_pc == 32'd31) m_halt = 1'b1;
                else m_pc = m_pc + 32'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en && !reset) begin
            chk("m_PC", PC, m_pc);
            chk("m_IR", IR, m_ir);
            chk("m_IR_Valid", {31'd0, IR_Valid}, {31'd0, m_v});
            chk("m_Halted", {31'd0, Halted}, {31'd0, m_halt});
            if (m_v) begin
                chk("m_IR_PC", IR_PC, m_irpc);
                chk("m_IR_Branch", {31'd0, IR_Branch}, {31'd0, m_br});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] t);
        RedirectValid = 1'b1; RedirectTarget = t;
        tick();
        RedirectValid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; Stall = 1'b0; RedirectValid = 1'b0; RedirectTarget = 32'd0;
        #1 reset = 1'b1;
        #2;
        chk("rst_PC", PC, 32'd0);
        chk("rst_IR", IR, 32'd0);
        chk("rst_IR_Valid", {31'd0, IR_Valid}, 32'd0);
        chk("rst_Halted", {31'd0, Halted}, 32'd0);
        chk_en = 1'b1;
        #9 reset = 1'b0;

        // free run 0..3
        tick();
        chk("run_PC1", PC, 32'd1);
        chk("run_IR0", IR, 32'hA000_0000);
        chk("run_V", {31'd0, IR_Valid}, 32'd1);
        tick(); chk("run_PC2", PC, 32'd2); chk("run_IR1", IR, 32'hA001_0101);
        tick(); chk("run_PC3", PC, 32'd3); chk("run_IR2", IR, 32'hA002_0202);
        tick(); chk("run_PC4", PC, 32'd4); chk("run_IR3", IR, 32'h8000_0003);
        chk("run_Branch", {31'd0, IR_Branch}, 32'd1);

        // jump at 21
        redirect(32'd20);
        chk("rd20_PC", PC, 32'd20);
        chk("rd20_V", {31'd0, IR_Valid}, 32'd0);
        tick(); chk("pc21", PC, 32'd21); chk("ir20", IR, 32'hA014_1414);
        tick();
`ifdef JUMP_PREDECODE_EN
        chk("jmp_PC", PC, 32'd0);
        chk("jmp_V", {31'd0, IR_Valid}, 32'd0);
        tick();
        chk("jmp_PC1", PC, 32'd1);
        chk("jmp_IR", IR, 32'hA000_0000);
        chk("jmp_V1", {31'd0, IR_Valid}, 32'd1);
`else
        chk("nj_PC", PC, 32'd22);
        chk("nj_IR", IR, 32'h0400_FFEA);
        chk("nj_V", {31'd0, IR_Valid}, 32'd1);
        tick();
        chk("nj_PC23", PC, 32'd23);
`endif

        // redirect while stalled at PC 21
        redirect(32'd21);
        chk("pc21b", PC, 32'd21);
        Stall = 1'b1;
        redirect(32'd16);
        Stall = 1'b0;
        chk("rds_PC", PC, 32'd16);
        chk("rds_V", {31'd0, IR_Valid}, 32'd0);
        tick();
        chk("rds_PC17", PC, 32'd17);
        chk("rds_IR", IR, 32'hA010_1010);

        // stall 3 cycles at PC 12
        redirect(32'd11);
        tick();
        chk("st_PC", PC, 32'd12);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_PC", PC, 32'd12);
            chk("st_hold_IR", IR, 32'hA00B_0B0B);
            chk("st_hold_IRPC", IR_PC, 32'd11);
        end
        Stall = 1'b0;
        tick();
        chk("st_res_PC", PC, 32'd13);
        chk("st_res_IRPC", IR_PC, 32'd12);

        // run to PROG_END
        redirect(32'd29);
        tick(); tick();
        chk("end_PC31", PC, 32'd31);
        tick();
        chk("end_IR31", IR, 32'hA01F_1F1F);
        chk("end_V", {31'd0, IR_Valid}, 32'd1);
        chk("end_PC", PC, 32'd31);
        tick();
        chk("halt_H", {31'd0, Halted}, 32'd1);
        chk("halt_V", {31'd0, IR_Valid}, 32'd0);
        chk("halt_PC", PC, 32'd31);
        tick();
        chk("halt_PC2", PC, 32'd31);
        redirect(32'd8);
        chk("unh_PC", PC, 32'd8);
        chk("unh_H", {31'd0, Halted}, 32'd0);
        tick();
        chk("unh_IR", IR, 32'hA008_0808);

        // async reset mid-bubble
        redirect(32'd5);
        #2 reset = 1'b1;
        #1;
        chk("ar_PC", PC, 32'd0);
        chk("ar_IR", IR, 32'd0);
        chk("ar_IRPC", IR_PC, 32'd0);
        chk("ar_V", {31'd0, IR_Valid}, 32'd0);
        chk("ar_Br", {31'd0, IR_Branch}, 32'd0);
        chk("ar_H", {31'd0, Halted}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("ar_run_PC", PC, 32'd1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
